// File: rtl/decoding_block_if.sv
// decoding_block_if
//   Groups the symbol-side inputs and byte-side outputs of the lane decoder.
//   master : symbol source / byte sink (deserializer + RX path side)
//   slave  : the decoder itself
// Signals:
//   enable, gen_speed[1:0]         block enable and link generation select
//   lane_0_rx_enc, lane_1_rx_enc   132-bit deserialized lane symbols
//   sym_valid                      one-cycle strobe, symbol inputs valid
//   lane_0_rx, lane_1_rx           decoded bytes
//   rx_valid, sym_start, os_flag   byte qualifiers
//   sync_err, ovf_err              one-cycle error pulses
interface decoding_block_if;
  logic         enable;
  logic [1:0]   gen_speed;
  logic [131:0] lane_0_rx_enc;
  logic [131:0] lane_1_rx_enc;
  logic         sym_valid;
  logic [7:0]   lane_0_rx;
  logic [7:0]   lane_1_rx;
  logic         rx_valid;
  logic         sym_start;
  logic         os_flag;
  logic         sync_err;
  logic         ovf_err;

  modport master (
    output enable, gen_speed, lane_0_rx_enc, lane_1_rx_enc, sym_valid,
    input  lane_0_rx, lane_1_rx, rx_valid, sym_start, os_flag, sync_err, ovf_err
  );

  modport slave (
    input  enable, gen_speed, lane_0_rx_enc, lane_1_rx_enc, sym_valid,
    output lane_0_rx, lane_1_rx, rx_valid, sym_start, os_flag, sync_err, ovf_err
  );
endinterface

// File: rtl/decoding_block.sv
// decoding_block
//   Receive-side lane decoder. Checks sync headers of two deserialized lane
//   symbols, strips them and unloads the payload one byte per lane per clock.
//   Gen3 = 128b/132b (16 bytes), Gen2 = 64b/66b (8 bytes), Gen4 = byte
//   pass-through of [7:0].
// Ports:
//   enc_clk  block clock
//   rst      asynchronous, active-low reset
//   bus      decoding_block_if.slave (enable, gen_speed, symbols, bytes, flags)
module decoding_block #(
  parameter logic [3:0] HDR3_OS = 4'b0101,
  parameter logic [3:0] HDR3_TP = 4'b1010,
  parameter logic [1:0] HDR2_OS = 2'b01,
  parameter logic [1:0] HDR2_TP = 2'b10
) (
  input logic             enc_clk,
  input logic             rst,
  decoding_block_if.slave bus
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] UNLOAD = 1'b1;

  logic [0:0]   state_q, state_d;
  logic [3:0]   idx_q, idx_d;         // index of the byte currently on the outputs
  logic         gen3_q, gen3_d;       // latched speed: 1 = Gen3, 0 = Gen2
  logic [127:0] pay0_q, pay0_d;       // remaining payload, next byte in [7:0]
  logic [127:0] pay1_q, pay1_d;
  logic [7:0]   lane0_q, lane0_d;
  logic [7:0]   lane1_q, lane1_d;
  logic         rx_valid_q, rx_valid_d;
  logic         sym_start_q, sym_start_d;
  logic         os_flag_q, os_flag_d;
  logic         sync_err_q, sync_err_d;
  logic         ovf_err_q, ovf_err_d;

  logic         sel_gen3;
  logic         sel_gen4;
  logic         last_byte;
  logic         mid_unload;
  logic         hdr_ok;
  logic         hdr_os;
  logic [127:0] new_pay0;
  logic [127:0] new_pay1;

  assign sel_gen3   = (bus.gen_speed == 2'd1);
  assign sel_gen4   = (bus.gen_speed == 2'd0) || (bus.gen_speed == 2'd3);
  assign last_byte  = gen3_q ? (idx_q == 4'd15) : (idx_q == 4'd7);
  // A new symbol is only accepted from IDLE or on the last-byte cycle.
  assign mid_unload = (state_q == UNLOAD) && !last_byte;

  // Header check and payload extraction for the speed currently requested.
  always_comb begin
    hdr_ok   = 1'b0;
    hdr_os   = 1'b0;
    new_pay0 = '0;
    new_pay1 = '0;
    if (sel_gen3) begin
      hdr_ok   = (bus.lane_0_rx_enc[3:0] == bus.lane_1_rx_enc[3:0]) &&
                 ((bus.lane_0_rx_enc[3:0] == HDR3_OS) || (bus.lane_0_rx_enc[3:0] == HDR3_TP));
      hdr_os   = (bus.lane_0_rx_enc[3:0] == HDR3_OS);
      new_pay0 = bus.lane_0_rx_enc[131:4];
      new_pay1 = bus.lane_1_rx_enc[131:4];
    end else begin
      hdr_ok   = (bus.lane_0_rx_enc[1:0] == bus.lane_1_rx_enc[1:0]) &&
                 ((bus.lane_0_rx_enc[1:0] == HDR2_OS) || (bus.lane_0_rx_enc[1:0] == HDR2_TP));
      hdr_os   = (bus.lane_0_rx_enc[1:0] == HDR2_OS);
      new_pay0 = {64'd0, bus.lane_0_rx_enc[65:2]};
      new_pay1 = {64'd0, bus.lane_1_rx_enc[65:2]};
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    gen3_d      = gen3_q;
    pay0_d      = pay0_q;
    pay1_d      = pay1_q;
    lane0_d     = 8'd0;
    lane1_d     = 8'd0;
    rx_valid_d  = 1'b0;
    sym_start_d = 1'b0;
    os_flag_d   = os_flag_q;
    sync_err_d  = 1'b0;
    ovf_err_d   = 1'b0;

    if (!bus.enable) begin
      state_d   = IDLE;
      idx_d     = 4'd0;
      gen3_d    = 1'b0;
      pay0_d    = '0;
      pay1_d    = '0;
      os_flag_d = 1'b0;
    end else if (mid_unload) begin
      // Continue the current symbol; any new strobe here is an overrun.
      lane0_d    = pay0_q[7:0];
      lane1_d    = pay1_q[7:0];
      pay0_d     = pay0_q >> 8;
      pay1_d     = pay1_q >> 8;
      rx_valid_d = 1'b1;
      idx_d      = idx_q + 4'd1;
      ovf_err_d  = bus.sym_valid;
    end else if (bus.sym_valid) begin
      idx_d = 4'd0;
      if (sel_gen4) begin
        lane0_d     = bus.lane_0_rx_enc[7:0];
        lane1_d     = bus.lane_1_rx_enc[7:0];
        rx_valid_d  = 1'b1;
        sym_start_d = 1'b1;
        os_flag_d   = 1'b0;
        state_d     = IDLE;
      end else begin
        gen3_d = sel_gen3;
        if (hdr_ok) begin
          // Byte 0 goes straight out; the rest is parked in the shifters.
          lane0_d     = new_pay0[7:0];
          lane1_d     = new_pay1[7:0];
          pay0_d      = new_pay0 >> 8;
          pay1_d      = new_pay1 >> 8;
          rx_valid_d  = 1'b1;
          sym_start_d = 1'b1;
          os_flag_d   = hdr_os;
          state_d     = UNLOAD;
        end else begin
          sync_err_d = 1'b1;
          state_d    = IDLE;
        end
      end
    end else begin
      state_d = IDLE;
      idx_d   = 4'd0;
    end
  end

  always_ff @(posedge enc_clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      idx_q       <= 4'd0;
      gen3_q      <= 1'b0;
      pay0_q      <= '0;
      pay1_q      <= '0;
      lane0_q     <= 8'd0;
      lane1_q     <= 8'd0;
      rx_valid_q  <= 1'b0;
      sym_start_q <= 1'b0;
      os_flag_q   <= 1'b0;
      sync_err_q  <= 1'b0;
      ovf_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      gen3_q      <= gen3_d;
      pay0_q      <= pay0_d;
      pay1_q      <= pay1_d;
      lane0_q     <= lane0_d;
      lane1_q     <= lane1_d;
      rx_valid_q  <= rx_valid_d;
      sym_start_q <= sym_start_d;
      os_flag_q   <= os_flag_d;
      sync_err_q  <= sync_err_d;
      ovf_err_q   <= ovf_err_d;
    end
  end

  assign bus.lane_0_rx = lane0_q;
  assign bus.lane_1_rx = lane1_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.sym_start = sym_start_q;
  assign bus.os_flag   = os_flag_q;
  assign bus.sync_err  = sync_err_q;
  assign bus.ovf_err   = ovf_err_q;

endmodule

// File: doc/decoding_block.md
Name: decoding_block

Overview:
- Receive-side counterpart of the lane encoder. Takes deserialized per-lane symbols and checks their sync headers.
- Strips the sync header and unloads the payload as a byte stream, one byte per lane per enc_clk, to the lane-deskew/logical RX path.
- Supports Gen3 (128b/132b), Gen2 (64b/66b) and Gen4 byte pass-through.
- Flags ordered-set vs transport payload, sync-header errors and symbol overrun.

Parameters:
- HDR3_OS, 4'b0101, Gen3 sync header for ordered-set symbols
- HDR3_TP, 4'b1010, Gen3 sync header for transport symbols
- HDR2_OS, 2'b01, Gen2 sync header for ordered-set symbols
- HDR2_TP, 2'b10, Gen2 sync header for transport symbols

Ports:
- enc_clk  in  1  block clock
- rst  in  1  asynchronous, active-low reset
- enable  in  1  block enable; low = synchronous flush
- gen_speed  in  2  0=Gen4 byte mode, 1=Gen3 132b, 2=Gen2 66b, 3=reserved (treated as Gen4)
- lane_0_rx_enc  in  132  lane 0 symbol; Gen3 uses [131:0], Gen2 uses [65:0], Gen4 uses [7:0]
- lane_1_rx_enc  in  132  lane 1 symbol, same layout
- sym_valid  in  1  one-cycle strobe: symbol inputs valid
- lane_0_rx  out  8  decoded lane 0 byte
- lane_1_rx  out  8  decoded lane 1 byte
- rx_valid  out  1  lane_x_rx valid this cycle
- sym_start  out  1  high with first byte of each symbol
- os_flag  out  1  1 = current symbol is an ordered set, 0 = transport; held for the whole symbol
- sync_err  out  1  one-cycle pulse: illegal or mismatched header, symbol dropped
- ovf_err  out  1  one-cycle pulse: sym_valid during mid-unload, new symbol dropped

Behaviour:
- Reset (rst=0, async): all outputs 0, state IDLE, byte counter 0, symbol registers 0.
- enable=0 (sync): same clearing as reset; sym_valid ignored.
- Symbol layout:
  - Gen3: header = [3:0]; byte k (k=0..15) = [12+8k-1 : 4+8k], so byte0 = [11:4] and byte15 = [131:124].
  - Gen2: header = [1:0]; byte k (k=0..7) = [9+8k : 2+8k].
  - Byte 0 is transmitted first.
- gen_speed is sampled at symbol capture and latched; a change mid-unload takes effect on the next capture.
- Header check at capture:
  - Both lanes' headers must equal each other and equal the OS or TP code for the latched speed.
  - Otherwise: pulse sync_err the next cycle, no bytes emitted, stay/return to IDLE.
- State IDLE:
  - sym_valid with a legal header captures both symbols, sets os_flag (1 if OS code), counter=0, goes to UNLOAD.
- State UNLOAD:
  - Each cycle: rx_valid=1, lane_x_rx = byte[counter], counter++.
  - sym_start=1 only when counter=0.
  - Latency: first byte appears on the cycle after the sym_valid cycle.
  - Last byte is counter=15 (Gen3) or 7 (Gen2).
  - After the last byte with no new symbol: return to IDLE, rx_valid=0, os_flag holds its last value.
- Back-to-back:
  - sym_valid on the last-byte cycle is accepted: the new symbol is captured and its byte0 follows with no gap.
  - A header error on that symbol pulses sync_err and goes to IDLE.
- Overrun: sym_valid during UNLOAD before the last byte pulses ovf_err next cycle, discards the new symbol, and the current unload continues unaffected.
- Gen4 (gen_speed 0/3):
  - No header and no FSM unload.
  - On sym_valid: next cycle lane_x_rx = lane_x_rx_enc[7:0], rx_valid=1, sym_start=1, os_flag=0; otherwise rx_valid=0.
  - A switch into Gen4 while in UNLOAD aborts nothing; the unload finishes first using the latched speed.
- Simultaneous sync_err and ovf_err is impossible: an overrun symbol is never header-checked.

Test Plan:
- Reset mid-unload → Gen3 transport symbol (header 4'b1010, bytes 0x00..0x0F per lane, lane1 = lane0 ^ 0xFF), rst low at byte 5 → all outputs 0 immediately, IDLE; next symbol decodes from byte0.
- Gen3 transport symbol, same stimulus as above without reset → 16 consecutive rx_valid cycles starting 1 cycle after sym_valid, lane_0_rx 0x00..0x0F, lane_1_rx 0xFF..0xF0, sym_start on first, os_flag=0.
- Gen2 ordered set, header 2'b01, two symbols with sym_valid 8 cycles apart → 16 contiguous bytes, no rx_valid gap, os_flag=1, sym_start on cycles 1 and 9.
- Bad headers:
  - Gen3, lane0 header 4'b0101, lane1 header 4'b1010 → sync_err one cycle, no rx_valid.
  - Repeat with both lanes 4'b1111 → same result.
- Overrun: Gen3 sym_valid at byte 3 of unload → ovf_err pulse, original 16 bytes intact, extra symbol never output.
- Gen4 byte mode: gen_speed=0, sym_valid with [7:0]=0xA5/0x5A → next cycle lane_0_rx=0xA5, lane_1_rx=0x5A, rx_valid=1; enable=0 for one cycle mid-stream → outputs cleared.
